// File: rtl/ucie_rx_ack_nak_tracker.sv
// UCIe D2D receive sequence tracker: in-order delivery,
// duplicate/bad-flit drop, coalesced ACK and NAK generation.
module ucie_rx_ack_nak_tracker #(
  parameter int FLIT_WIDTH   = 256,
  parameter int ACK_COALESCE = 4,
  parameter int ACK_TIMEOUT  = 64,
  parameter int NAK_TIMEOUT  = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FLIT_WIDTH-1:0] rx_flit_in,
  input  logic                  rx_flit_valid,
  output logic                  rx_flit_ready,
  input  logic [7:0]            rx_seq_num,
  input  logic                  rx_crc_error,
  output logic [FLIT_WIDTH-1:0] dl_flit_out,
  output logic                  dl_flit_valid,
  input  logic                  dl_flit_ready,
  output logic                  ack_valid,
  output logic                  ack_is_nak,
  output logic [7:0]            ack_seq_num,
  input  logic                  ack_ready,
  output logic [7:0]            expected_seq,
  output logic [15:0]           nak_count,
  output logic [15:0]           drop_count,
  output logic [1:0]            tracker_state
);

  localparam int UW  = $clog2(ACK_COALESCE + 1) + 1;
  localparam int ATW = $clog2(ACK_TIMEOUT + 1);
  localparam int RTW = $clog2(NAK_TIMEOUT + 1);

  localparam logic [UW-1:0]  COAL     = UW'(ACK_COALESCE);
  localparam logic [ATW-1:0] ATO      = ATW'(ACK_TIMEOUT);
  localparam logic [RTW-1:0] RTO_LAST = RTW'(NAK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_NORMAL      = 2'd0,
    ST_NAK_PEND    = 2'd1,
    ST_WAIT_REPLAY = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [FLIT_WIDTH-1:0] r_dl_data;
  logic                  r_dl_valid;
  logic [7:0]            r_exp;
  logic                  r_ack_valid;
  logic                  r_ack_nak;
  logic [7:0]            r_ack_seq;
  logic [15:0]           r_nak_cnt;
  logic [15:0]           r_drop_cnt;
  logic [UW-1:0]         r_unacked;
  logic [UW-1:0]         r_covered;
  logic [ATW-1:0]        r_ack_tmr;
  logic                  r_force;
  logic [RTW-1:0]        r_rtmr;

  logic          w_accept;
  logic [7:0]    w_diff;
  logic          w_good;
  logic          w_dup;
  logic          w_bad;
  logic          w_hs;
  logic          w_ack_hs;
  logic          w_deliver;
  logic          w_drop;
  logic          w_nak_inc;
  logic          w_rtmr_clr;
  logic          w_nak_raise;
  logic          w_ack_cond;
  logic          w_ack_raise;
  logic [UW-1:0] w_ubase;
  logic [UW:0]   w_usum;
  logic [UW-1:0] w_unacked_nxt;

  assign rx_flit_ready = !r_dl_valid || dl_flit_ready;

  assign w_accept = rx_flit_valid && rx_flit_ready;
  assign w_diff   = r_exp - rx_seq_num;
  assign w_good   = w_accept && !rx_crc_error
                    && (rx_seq_num == r_exp);
  assign w_dup    = w_accept && !rx_crc_error
                    && (w_diff != 8'd0) && !w_diff[7];
  assign w_bad    = w_accept && !w_good && !w_dup;
  assign w_hs     = r_ack_valid && ack_ready;
  assign w_ack_hs = w_hs && !r_ack_nak;

  assign w_deliver = w_good && (r_state != ST_NAK_PEND);
  assign w_drop    = w_accept && !w_deliver;

  always_comb begin
    w_state_nxt = r_state;
    w_nak_inc   = 1'b0;
    w_rtmr_clr  = 1'b0;
    unique case (r_state)
      ST_NORMAL: begin
        if (w_bad) begin
          w_state_nxt = ST_NAK_PEND;
          w_nak_inc   = 1'b1;
        end
      end
      ST_NAK_PEND: begin
        if (w_hs && r_ack_nak) begin
          w_state_nxt = ST_WAIT_REPLAY;
          w_rtmr_clr  = 1'b1;
        end
      end
      ST_WAIT_REPLAY: begin
        if (w_good) begin
          w_state_nxt = ST_NORMAL;
        end else if (r_rtmr == RTO_LAST) begin
          w_state_nxt = ST_NAK_PEND;
          w_nak_inc   = 1'b1;
        end
      end
      default: w_state_nxt = ST_NORMAL;
    endcase
  end

  // A NAK may take over the channel on the edge its ACK completes.
  assign w_nak_raise = (w_state_nxt == ST_NAK_PEND)
                       && (!r_ack_valid || w_ack_hs);

  assign w_ack_cond = (r_unacked >= COAL)
                      || ((r_unacked != '0) && (r_ack_tmr >= ATO))
                      || r_force;
  assign w_ack_raise = (r_state == ST_NORMAL)
                       && (w_state_nxt == ST_NORMAL)
                       && !r_ack_valid && w_ack_cond;

  assign w_ubase = w_ack_hs ? (r_unacked - r_covered) : r_unacked;
  assign w_usum  = {1'b0, w_ubase}
                   + {{UW{1'b0}},
                      (w_deliver && (r_state == ST_NORMAL))};
  assign w_unacked_nxt = w_usum[UW] ? {UW{1'b1}} : w_usum[UW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_NORMAL;
      r_dl_data  <= '0;
      r_dl_valid <= 1'b0;
      r_exp      <= 8'd0;
      r_ack_valid <= 1'b0;
      r_ack_nak  <= 1'b0;
      r_ack_seq  <= 8'd0;
      r_nak_cnt  <= 16'd0;
      r_drop_cnt <= 16'd0;
      r_unacked  <= '0;
      r_covered  <= '0;
      r_ack_tmr  <= '0;
      r_force    <= 1'b0;
      r_rtmr     <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (w_deliver) begin
        r_dl_valid <= 1'b1;
        r_dl_data  <= rx_flit_in;
        r_exp      <= r_exp + 8'd1;
      end else if (dl_flit_ready) begin
        r_dl_valid <= 1'b0;
      end

      if (w_nak_raise) begin
        r_ack_valid <= 1'b1;
        r_ack_nak   <= 1'b1;
        r_ack_seq   <= r_exp - 8'd1;
      end else if (w_ack_raise) begin
        r_ack_valid <= 1'b1;
        r_ack_nak   <= 1'b0;
        r_ack_seq   <= r_exp - 8'd1;
        r_covered   <= r_unacked;
      end else if (w_hs) begin
        r_ack_valid <= 1'b0;
      end

      if (w_deliver && (r_state == ST_WAIT_REPLAY)) begin
        r_unacked <= {{(UW-1){1'b0}}, 1'b1};
        r_ack_tmr <= '0;
      end else begin
        r_unacked <= w_unacked_nxt;
        if (w_ack_hs)
          r_ack_tmr <= '0;
        else if ((r_unacked != '0) && !r_ack_valid
                 && (r_ack_tmr != ATO))
          r_ack_tmr <= r_ack_tmr + 1'b1;
      end

      // A duplicate seen during an ACK handshake still earns an ACK.
      if ((r_state == ST_NORMAL) && w_dup)
        r_force <= 1'b1;
      else if (w_ack_hs)
        r_force <= 1'b0;

      if (w_rtmr_clr)
        r_rtmr <= '0;
      else if ((r_state == ST_WAIT_REPLAY) && (r_rtmr != RTO_LAST))
        r_rtmr <= r_rtmr + 1'b1;

      if (w_nak_inc && (r_nak_cnt != 16'hFFFF))
        r_nak_cnt <= r_nak_cnt + 16'd1;
      if (w_drop && (r_drop_cnt != 16'hFFFF))
        r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign dl_flit_out   = r_dl_data;
  assign dl_flit_valid = r_dl_valid;
  assign ack_valid     = r_ack_valid;
  assign ack_is_nak    = r_ack_nak;
  assign ack_seq_num   = r_ack_seq;
  assign expected_seq  = r_exp;
  assign nak_count     = r_nak_cnt;
  assign drop_count    = r_drop_cnt;
  assign tracker_state = r_state;

endmodule

// File: tb/tb_ucie_rx_ack_nak_tracker.sv
// Directed bench for ucie_rx_ack_nak_tracker: delivery order,
// NAK/replay, timeouts, duplicates, wrap and back-pressure.
module tb_ucie_rx_ack_nak_tracker;

  logic         clk;
  logic         rst;
  logic [255:0] rx_flit_in;
  logic         rx_flit_valid;
  logic         rx_flit_ready;
  logic [7:0]   rx_seq_num;
  logic         rx_crc_error;
  logic [255:0] dl_flit_out;
  logic         dl_flit_valid;
  logic         dl_flit_ready;
  logic         ack_valid;
  logic         ack_is_nak;
  logic [7:0]   ack_seq_num;
  logic         ack_ready;
  logic [7:0]   expected_seq;
  logic [15:0]  nak_count;
  logic [15:0]  drop_count;
  logic [1:0]   tracker_state;

  int n_chk;
  int n_pass;

  logic [7:0] dq[$];
  logic [8:0] aq[$];

  ucie_rx_ack_nak_tracker dut (
    .clk          (clk),
    .rst          (rst),
    .rx_flit_in   (rx_flit_in),
    .rx_flit_valid(rx_flit_valid),
    .rx_flit_ready(rx_flit_ready),
    .rx_seq_num   (rx_seq_num),
    .rx_crc_error (rx_crc_error),
    .dl_flit_out  (dl_flit_out),
    .dl_flit_valid(dl_flit_valid),
    .dl_flit_ready(dl_flit_ready),
    .ack_valid    (ack_valid),
    .ack_is_nak   (ack_is_nak),
    .ack_seq_num  (ack_seq_num),
    .ack_ready    (ack_ready),
    .expected_seq (expected_seq),
    .nak_count    (nak_count),
    .drop_count   (drop_count),
    .tracker_state(tracker_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (dl_flit_valid && dl_flit_ready)
        dq.push_back(dl_flit_out[7:0]);
      if (ack_valid && ack_ready)
        aq.push_back({ack_is_nak, ack_seq_num});
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] s, input logic e);
    rx_flit_valid = 1'b1;
    rx_seq_num    = s;
    rx_crc_error  = e;
    rx_flit_in    = {{31{8'hA5}}, s};
    tick();
  endtask

  task automatic idle(input int n);
    rx_flit_valid = 1'b0;
    rx_crc_error  = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    rx_flit_valid = 1'b0;
    rx_crc_error  = 1'b0;
    rx_seq_num    = 8'd0;
    rx_flit_in    = '0;
    dl_flit_ready = 1'b1;
    ack_ready     = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    dq.delete();
    aq.delete();
  endtask

  initial begin
    int n;
    n_chk  = 0;
    n_pass = 0;

    // reset values
    rst           = 1'b1;
    rx_flit_valid = 1'b0;
    rx_crc_error  = 1'b0;
    rx_seq_num    = 8'd0;
    rx_flit_in    = '0;
    dl_flit_ready = 1'b1;
    ack_ready     = 1'b1;
    repeat (2) tick();
    chk("rst_dlv", dl_flit_valid, 1'b0);
    chk("rst_ackv", ack_valid, 1'b0);
    chk("rst_nak", ack_is_nak, 1'b0);
    chk("rst_aseq", ack_seq_num, 8'd0);
    chk("rst_exp", expected_seq, 8'd0);
    chk("rst_nakc", nak_count, 16'd0);
    chk("rst_drop", drop_count, 16'd0);
    chk("rst_st", tracker_state, 2'd0);
    chk("rst_dout", dl_flit_out[31:0], 32'd0);

    // in-order stream 0..7
    do_reset();
    for (int i = 0; i < 8; i++) send(8'(i), 1'b0);
    idle(10);
    chk("t1_ndl", dq.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < dq.size()) chk("t1_dl", dq[i], 8'(i));
    chk("t1_nack", aq.size(), 2);
    if (aq.size() >= 2) begin
      chk("t1_ack0", aq[0], 9'h003);
      chk("t1_ack1", aq[1], 9'h007);
    end
    chk("t1_exp", expected_seq, 8'd8);
    chk("t1_drop", drop_count, 16'd0);

    // CRC error then replay
    do_reset();
    send(8'd0, 1'b0);
    send(8'd1, 1'b0);
    send(8'd2, 1'b1);
    chk("t2_st1", tracker_state, 2'd1);
    chk("t2_av", ack_valid, 1'b1);
    chk("t2_isnak", ack_is_nak, 1'b1);
    chk("t2_aseq", ack_seq_num, 8'd1);
    send(8'd3, 1'b0);
    chk("t2_st2", tracker_state, 2'd2);
    idle(2);
    send(8'd2, 1'b0);
    idle(1);
    chk("t2_st0", tracker_state, 2'd0);
    chk("t2_exp", expected_seq, 8'd3);
    chk("t2_drop", drop_count, 16'd2);
    chk("t2_nakc", nak_count, 16'd1);
    chk("t2_ndl", dq.size(), 3);
    if (dq.size() >= 3) chk("t2_dl2", dq[2], 8'd2);

    // replay timeout re-issues NAK
    do_reset();
    send(8'd0, 1'b0);
    send(8'd1, 1'b0);
    send(8'd2, 1'b1);
    idle(1);
    chk("t3_st2", tracker_state, 2'd2);
    n = 0;
    while (n < 1100) begin
      tick();
      n++;
      if (ack_valid) break;
    end
    chk("t3_wait", n, 1024);
    chk("t3_isnak", ack_is_nak, 1'b1);
    chk("t3_aseq", ack_seq_num, 8'd1);
    chk("t3_nakc", nak_count, 16'd2);

    // duplicate forces an ACK
    do_reset();
    for (int i = 0; i < 5; i++) send(8'(i), 1'b0);
    idle(3);
    aq.delete();
    chk("t4_exp", expected_seq, 8'd5);
    send(8'd3, 1'b0);
    idle(3);
    chk("t4_nack", aq.size(), 1);
    if (aq.size() >= 1) chk("t4_ack", aq[0], 9'h004);
    chk("t4_drop", drop_count, 16'd1);
    chk("t4_nakc", nak_count, 16'd0);
    chk("t4_st", tracker_state, 2'd0);

    // sequence wrap and ACK timeout
    do_reset();
    for (int i = 0; i < 254; i++) send(8'(i), 1'b0);
    idle(100);
    aq.delete();
    chk("t5_exp254", expected_seq, 8'd254);
    send(8'd254, 1'b0);
    send(8'd255, 1'b0);
    send(8'd0, 1'b0);
    rx_flit_valid = 1'b0;
    chk("t5_exp1", expected_seq, 8'd1);
    n = 0;
    while (n < 200) begin
      tick();
      n++;
      if (ack_valid) break;
    end
    chk("t5_wait", n, 63);
    chk("t5_isnak", ack_is_nak, 1'b0);
    chk("t5_aseq", ack_seq_num, 8'd0);

    // ACK stalled, then BAD beat
    do_reset();
    ack_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(8'(i), 1'b0);
    idle(3);
    chk("t6_av", ack_valid, 1'b1);
    chk("t6_aseq", ack_seq_num, 8'd3);
    send(8'd4, 1'b1);
    rx_flit_valid = 1'b0;
    chk("t6_st1", tracker_state, 2'd1);
    chk("t6_hold", {ack_valid, ack_is_nak, ack_seq_num},
        {2'b10, 8'd3});
    idle(2);
    chk("t6_hold2", {ack_valid, ack_is_nak, ack_seq_num},
        {2'b10, 8'd3});
    ack_ready = 1'b1;
    tick();
    chk("t6_nak", {ack_valid, ack_is_nak, ack_seq_num},
        {2'b11, 8'd3});
    tick();
    chk("t6_st2", tracker_state, 2'd2);

    // delivery back-pressure
    do_reset();
    dl_flit_ready = 1'b0;
    #1;
    chk("t7_rdy0", rx_flit_ready, 1'b1);
    send(8'd0, 1'b0);
    chk("t7_dlv", dl_flit_valid, 1'b1);
    chk("t7_rdy1", rx_flit_ready, 1'b0);
    send(8'd1, 1'b0);
    chk("t7_exp1", expected_seq, 8'd1);
    dl_flit_ready = 1'b1;
    #1;
    chk("t7_rdy2", rx_flit_ready, 1'b1);
    tick();
    rx_flit_valid = 1'b0;
    chk("t7_exp2", expected_seq, 8'd2);

    // reset while ACK outstanding
    do_reset();
    ack_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(8'(i), 1'b0);
    idle(2);
    chk("t8_av", ack_valid, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("t8_av0", ack_valid, 1'b0);
    chk("t8_exp", expected_seq, 8'd0);
    chk("t8_dlv", dl_flit_valid, 1'b0);
    tick();
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
